jk_excite_seq: RTL
==================

Name: jk_excite_seq

Overview:
- Driver side of the JK flip-flop interface: a W-bit modulo up/down sequencer that generates J/K excitation vectors for an external bank of W negedge JK flip-flops.
- Runs on the rising edge of clk, so J/K are stable half a cycle before the flip-flops sample on the falling edge.
- Tracks the expected register value internally and, optionally, checks the flip-flop outputs fed back to it.

Parameters:
W, 4, width of the driven JK register and of the internal count.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  synchronous enable; when low, state holds and j/k load 0.
start  input  1  begin a sequence (IDLE or ERROR only).
stop  input  1  abort a sequence; returns to IDLE.
up_dn  input  1  1 = count up, 0 = count down; sampled every RUN step.
mod_max  input  W  terminal count; sequence is 0..mod_max.
q_fb  input  W  q outputs of the external JK bank.
j  output  W  registered J excitation vector.
k  output  W  registered K excitation vector.
count  output  W  value the external bank is expected to hold after the next falling edge.
busy  output  1  high in INIT and RUN.
wrap  output  1  one-cycle pulse on the RUN step that wraps.
err  output  1  sticky feedback-mismatch flag.

Behaviour:
- Reset (async): state=IDLE, j=0, k=0, count=0, busy=0, wrap=0, err=0.
- Excitation is always set/reset form, never toggle: j = next & ~cur, k = ~next & cur. J=K=1 is never driven, so re-applying a vector is idempotent.
- States: IDLE, INIT, RUN, ERROR (ERROR exists only with the feature).
- enable=0 edge: j<=0, k<=0, wrap<=0. State, count and err hold. No feedback check on that edge.
- IDLE:
  - j=k=0.
  - stop=1 keeps IDLE (stop beats start).
  - start=1 -> INIT.
- INIT (1 cycle):
  - On entry: j<=0, k<=all ones (clear bank), count<=0, busy<=1.
  - Next edge: -> RUN, performing the first step.
- RUN, each enabled edge:
  - stop=1: j<=0, k<=0, busy<=0, count holds, -> IDLE. stop has priority over the step.
  - Otherwise next is computed as:
    - up: next = (count>=mod_max) ? 0 : count+1.
    - down: next = (count==0 || count>mod_max) ? mod_max : count-1.
  - Then j/k are driven per the excitation rule and count<=next.
  - wrap<=1 iff up and next==0, or down and next==mod_max with count==0.
  - start is ignored in RUN.
- mod_max=0: count stays 0, j=k=0, wrap pulses every step.
- Latency: a step issued at posedge t appears on q_fb after the negedge in cycle t and is compared at posedge t+1.

Optional Feature:
JK_EXCITE_FB_CHECK_EN
- Defined:
  - An internal chk_v flag is set on INIT and RUN edges and cleared in IDLE/ERROR.
  - On an enabled edge with chk_v=1 and state RUN, q_fb!=count -> ERROR: j<=0, k<=0, busy<=0, err<=1. The compare takes priority over stop and the step.
  - From ERROR, start clears err and enters INIT. Reset also clears it.
- Undefined: q_fb is unused, err is constant 0, and no ERROR state exists.

Decomposition:
- Shared package: state enum (IDLE, INIT, RUN, ERROR) and the excitation function (cur, next -> j, k), reusable by other JK drivers.
- Sub-module jk_excite_step: combinational next-value and wrap computation (count, mod_max, up_dn -> next, wrap). The FSM stays in the top module.

Test Plan:
- W=4, mod_max=5, up, start → INIT drives k=4'hF; count then steps 1,2,3,4,5,0. Step 2->3 gives j=4'b0001, k=0. Step 5->0 gives j=0, k=4'b0101 with wrap=1.
- Down with mod_max=3 from INIT → count 3,2,1,0,3; wrap on the 0->3 step.
- stop asserted mid-RUN at count=2 → next edge j=k=0, busy=0, count=2. start and stop together in IDLE → stays IDLE.
- enable low for 3 edges at count=4 → j=k=0 and count holds at 4. Re-enable → step to 5 with j=4'b0001.
- Reset asserted mid-RUN between edges → outputs return to 0 immediately, without waiting for clk.
- JK_EXCITE_FB_CHECK_EN defined, model bank with bit0 stuck at 0 → first RUN compare with count=1 sets err=1, busy=0, j=k=0. A later start clears err.

Source files
------------

// File: rtl/jk_excite_seq_pkg.sv
// Shared definitions for JK flip-flop driver blocks.
//   jk_state_e : sequencer state encoding (Error is only reachable when the
//                feedback check is compiled in).
//   jk_exc_t   : J/K excitation pair, JkMaxW bits wide; callers zero-extend
//                their operands and keep the low bits they need.
//   jk_excite  : set/reset-form excitation from current and next register
//                value. J=K=1 is never produced, so re-applying a vector is
//                idempotent on the flip-flop bank.
package jk_excite_seq_pkg;

  localparam int unsigned JkMaxW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StInit  = 2'd1,
    StRun   = 2'd2,
    StError = 2'd3
  } jk_state_e;

  typedef struct packed {
    logic [JkMaxW-1:0] j;
    logic [JkMaxW-1:0] k;
  } jk_exc_t;

  function automatic jk_exc_t jk_excite(input logic [JkMaxW-1:0] cur,
                                        input logic [JkMaxW-1:0] nxt);
    jk_exc_t e;
    e.j = nxt & ~cur;
    e.k = ~nxt & cur;
    return e;
  endfunction

endpackage

// File: rtl/jk_excite_step.sv
// Combinational modulo up/down step for the JK excitation sequencer.
// Ports:
//   count   : current count
//   mod_max : terminal count, sequence runs 0..mod_max
//   up_dn   : 1 = up, 0 = down
//   next    : next count value
//   wrap    : this step wraps the sequence
// An out-of-range count (above mod_max) recovers to 0 going up and to
// mod_max going down.
module jk_excite_step #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] count,
  input  logic [W-1:0] mod_max,
  input  logic         up_dn,
  output logic [W-1:0] next,
  output logic         wrap
);

  always_comb begin
    next = '0;
    wrap = 1'b0;
    if (up_dn) begin
      if (count >= mod_max) begin
        next = '0;
      end else begin
        next = count + W'(1);
      end
      wrap = (next == '0);
    end else begin
      if ((count == '0) || (count > mod_max)) begin
        next = mod_max;
      end else begin
        next = count - W'(1);
      end
      // Only a step out of zero counts as a wrap; recovering from an
      // out-of-range value does not.
      wrap = (count == '0);
    end
  end

endmodule

// File: rtl/jk_excite_seq.sv
// W-bit modulo up/down sequencer driving J/K excitation into an external
// bank of negedge JK flip-flops. State updates on posedge so J/K are stable
// half a cycle before the bank samples.
// Optional feature macro: JK_EXCITE_FB_CHECK_EN -- compares q_fb against the
// expected count during Run and latches a sticky err on mismatch.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : synchronous enable; low holds state and drives j=k=0
//   start, stop       : begin / abort a sequence
//   up_dn             : count direction, sampled every Run step
//   mod_max           : terminal count
//   q_fb              : feedback from the JK bank (unused without the feature)
//   j, k              : registered excitation vectors
//   count             : value the bank should hold after the next negedge
//   busy, wrap, err   : in Init/Run, wrap pulse, sticky feedback error
module jk_excite_seq
  import jk_excite_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         start,
  input  logic         stop,
  input  logic         up_dn,
  input  logic [W-1:0] mod_max,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         wrap,
  output logic         err
);

  jk_state_e    state_q, state_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] count_q, count_d;
  logic         busy_q, busy_d;
  logic         wrap_q, wrap_d;

  logic [W-1:0] step_next;
  logic         step_wrap;
  jk_exc_t      exc;

  jk_excite_step #(
    .W(W)
  ) u_step (
    .count  (count_q),
    .mod_max(mod_max),
    .up_dn  (up_dn),
    .next   (step_next),
    .wrap   (step_wrap)
  );

  assign exc = jk_excite(JkMaxW'(count_q), JkMaxW'(step_next));

  if (W < JkMaxW) begin : g_exc_hi
    logic unused_exc_hi;
    assign unused_exc_hi = ^{exc.j[JkMaxW-1:W], exc.k[JkMaxW-1:W]};
  end

`ifdef JK_EXCITE_FB_CHECK_EN
  logic err_q, err_d;
  logic chk_v_q, chk_v_d;
  logic fb_bad;

  // chk_v marks that count_q reflects a vector the bank has had a negedge
  // to absorb.
  assign fb_bad = chk_v_q && (q_fb != count_q);
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
`endif

  always_comb begin
    state_d = state_q;
    j_d     = '0;
    k_d     = '0;
    count_d = count_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
`ifdef JK_EXCITE_FB_CHECK_EN
    err_d   = err_q;
    chk_v_d = chk_v_q;
`endif
    if (enable) begin
`ifdef JK_EXCITE_FB_CHECK_EN
      chk_v_d = (state_q == StInit) || (state_q == StRun);
`endif
      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_d = StInit;
            k_d     = '1;
            count_d = '0;
            busy_d  = 1'b1;
          end
        end
        StInit: begin
          state_d = StRun;
          j_d     = exc.j[W-1:0];
          k_d     = exc.k[W-1:0];
          count_d = step_next;
          wrap_d  = step_wrap;
        end
        StRun: begin
`ifdef JK_EXCITE_FB_CHECK_EN
          if (fb_bad) begin
            state_d = StError;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else
`endif
          if (stop) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            j_d     = exc.j[W-1:0];
            k_d     = exc.k[W-1:0];
            count_d = step_next;
            wrap_d  = step_wrap;
          end
        end
`ifdef JK_EXCITE_FB_CHECK_EN
        StError: begin
          if (start) begin
            state_d = StInit;
            k_d     = '1;
            count_d = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      j_q     <= '0;
      k_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef JK_EXCITE_FB_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q   <= 1'b0;
      chk_v_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      chk_v_q <= chk_v_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign j     = j_q;
  assign k     = k_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;

endmodule
